// File: rtl/ncpu32k_i_mmu_tlb_pkg.sv
// Shared definitions for the instruction MMU: TLB entry bit positions,
// default geometry and the exception state encoding.
package ncpu32k_i_mmu_tlb_pkg;

    localparam int TLBL_V_BIT  = 0;
    localparam int TLBH_P_BIT  = 0;
    localparam int TLBH_UX_BIT = 1;
    localparam int TLBH_SX_BIT = 2;

    localparam int PAGE_SHIFT_DEF     = 13;
    localparam int TLB_NSETS_LOG2_DEF = 2;
    localparam int TLB_NSETS_LOG2_MIN = 1;
    localparam int TLB_NSETS_LOG2_MAX = 7;

    typedef enum logic [1:0] {
        EXC_NONE,
        EXC_TLB_MISS,
        EXC_PAGE_FAULT
    } exc_state_e;

endpackage

// File: rtl/ncpu32k_i_tlb_array.sv
// Direct-mapped TLB storage: entry flops, MSR write/read ports and the
// combinational lookup that yields hit, PPN and permission bits.
module ncpu32k_i_tlb_array
    import ncpu32k_i_mmu_tlb_pkg::*;
#(
    parameter int TLB_NSETS_LOG2 = TLB_NSETS_LOG2_DEF,
    parameter int PAGE_SHIFT     = PAGE_SHIFT_DEF,
    parameter int AW             = 32,
    parameter int DW             = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW-PAGE_SHIFT-1:0]  lookup_vpn_i,
    output logic                      hit_o,
    output logic [AW-PAGE_SHIFT-1:0]  ppn_o,
    output logic                      p_o,
    output logic                      ux_o,
    output logic                      sx_o,
    input  logic [TLB_NSETS_LOG2-1:0] tlbl_idx_i,
    input  logic [DW-1:0]             tlbl_nxt_i,
    input  logic                      tlbl_we_i,
    output logic [DW-1:0]             tlbl_o,
    input  logic [TLB_NSETS_LOG2-1:0] tlbh_idx_i,
    input  logic [DW-1:0]             tlbh_nxt_i,
    input  logic                      tlbh_we_i,
    output logic [DW-1:0]             tlbh_o
);

    localparam int NSETS = 1 << TLB_NSETS_LOG2;
    localparam int VW    = AW - PAGE_SHIFT;

    logic [DW-1:0] tlbl_q [NSETS];
    logic [DW-1:0] tlbh_q [NSETS];
    logic [TLB_NSETS_LOG2-1:0] lookup_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSETS; i++) begin
                tlbl_q[i] <= '0;
                tlbh_q[i] <= '0;
            end
        end else begin
            if (tlbl_we_i) tlbl_q[tlbl_idx_i] <= tlbl_nxt_i;
            if (tlbh_we_i) tlbh_q[tlbh_idx_i] <= tlbh_nxt_i;
        end
    end

    assign tlbl_o = tlbl_q[tlbl_idx_i];
    assign tlbh_o = tlbh_q[tlbh_idx_i];

    // Low VPN bits select the set; the full VPN is still compared as the tag.
    assign lookup_idx = lookup_vpn_i[TLB_NSETS_LOG2-1:0];
    assign hit_o = tlbl_q[lookup_idx][TLBL_V_BIT] &
                   (tlbl_q[lookup_idx][PAGE_SHIFT +: VW] == lookup_vpn_i);
    assign ppn_o = tlbh_q[lookup_idx][PAGE_SHIFT +: VW];
    assign p_o   = tlbh_q[lookup_idx][TLBH_P_BIT];
    assign ux_o  = tlbh_q[lookup_idx][TLBH_UX_BIT];
    assign sx_o  = tlbh_q[lookup_idx][TLBH_SX_BIT];

endmodule

// File: rtl/ncpu32k_i_mmu_tlb.sv
// Instruction MMU: one registered lookup stage between the IFU and icache
// command ports, with sticky TLB-miss / page-fault reporting and flush recovery.
module ncpu32k_i_mmu_tlb
    import ncpu32k_i_mmu_tlb_pkg::*;
#(
    parameter int TLB_NSETS_LOG2 = TLB_NSETS_LOG2_DEF,
    parameter int PAGE_SHIFT     = PAGE_SHIFT_DEF,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int IW             = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ibus_cmd_valid,
    output logic                      ibus_cmd_ready,
    input  logic [AW-1:0]             ibus_cmd_addr,
    input  logic                      ibus_cmd_flush,
    output logic                      ibus_flush_ack,
    output logic                      icache_cmd_valid,
    input  logic                      icache_cmd_ready,
    output logic [AW-1:0]             icache_cmd_addr,
    input  logic                      icache_dout_valid,
    output logic                      icache_dout_ready,
    input  logic [IW-1:0]             icache_dout,
    output logic                      ibus_dout_valid,
    input  logic                      ibus_dout_ready,
    output logic [IW-1:0]             ibus_dout,
    input  logic                      msr_psr_imme,
    input  logic                      msr_psr_rm,
    output logic                      exp_tlb_miss,
    output logic                      exp_page_fault,
    output logic [AW-1:0]             exp_va,
    output logic [DW-1:0]             msr_immid,
    output logic [DW-1:0]             msr_imm_tlbl,
    input  logic [TLB_NSETS_LOG2-1:0] msr_imm_tlbl_idx,
    input  logic [DW-1:0]             msr_imm_tlbl_nxt,
    input  logic                      msr_imm_tlbl_we,
    output logic [DW-1:0]             msr_imm_tlbh,
    input  logic [TLB_NSETS_LOG2-1:0] msr_imm_tlbh_idx,
    input  logic [DW-1:0]             msr_imm_tlbh_nxt,
    input  logic                      msr_imm_tlbh_we
);

    localparam int VW = AW - PAGE_SHIFT;
    localparam logic [2:0] NSETS_LOG2_FIELD = 3'(TLB_NSETS_LOG2);

    if (TLB_NSETS_LOG2 < TLB_NSETS_LOG2_MIN || TLB_NSETS_LOG2 > TLB_NSETS_LOG2_MAX) begin : g_bad_nsets
        $error("TLB_NSETS_LOG2 out of supported range");
    end

    logic          s1_vld_q, s1_vld_d;
    logic [AW-1:0] s1_va_q, s1_va_d;
    exc_state_e    exc_q;
    logic          miss_q, pfault_q, flush_ack_q;
    logic [AW-1:0] exp_va_q;

    logic          tlb_hit, tlb_p, tlb_ux, tlb_sx, tlb_ok;
    logic [VW-1:0] tlb_ppn;
    logic          exp_pend, icache_hs, ibus_hs;

    ncpu32k_i_tlb_array #(
        .TLB_NSETS_LOG2 (TLB_NSETS_LOG2),
        .PAGE_SHIFT     (PAGE_SHIFT),
        .AW             (AW),
        .DW             (DW)
    ) u_tlb (
        .clk          (clk),
        .rst          (rst),
        .lookup_vpn_i (s1_va_q[AW-1:PAGE_SHIFT]),
        .hit_o        (tlb_hit),
        .ppn_o        (tlb_ppn),
        .p_o          (tlb_p),
        .ux_o         (tlb_ux),
        .sx_o         (tlb_sx),
        .tlbl_idx_i   (msr_imm_tlbl_idx),
        .tlbl_nxt_i   (msr_imm_tlbl_nxt),
        .tlbl_we_i    (msr_imm_tlbl_we),
        .tlbl_o       (msr_imm_tlbl),
        .tlbh_idx_i   (msr_imm_tlbh_idx),
        .tlbh_nxt_i   (msr_imm_tlbh_nxt),
        .tlbh_we_i    (msr_imm_tlbh_we),
        .tlbh_o       (msr_imm_tlbh)
    );

    // Privilege mode is sampled here, at lookup time, not when the VA was accepted.
    assign tlb_ok   = tlb_hit & tlb_p & (msr_psr_rm ? tlb_sx : tlb_ux);
    assign exp_pend = (exc_q != EXC_NONE);

    assign icache_cmd_valid = s1_vld_q & ~ibus_cmd_flush & ~exp_pend & (~msr_psr_imme | tlb_ok);
    assign icache_cmd_addr  = msr_psr_imme ? {tlb_ppn, s1_va_q[PAGE_SHIFT-1:0]} : s1_va_q;
    assign icache_hs        = icache_cmd_valid & icache_cmd_ready;
    assign ibus_cmd_ready   = ibus_cmd_flush | (~exp_pend & (~s1_vld_q | icache_hs));
    assign ibus_hs          = ibus_cmd_valid & ibus_cmd_ready;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_va_d  = s1_va_q;
        if (ibus_cmd_flush) begin
            s1_vld_d = ibus_cmd_valid;
            if (ibus_cmd_valid) s1_va_d = ibus_cmd_addr;
        end else if (ibus_hs) begin
            s1_vld_d = 1'b1;
            s1_va_d  = ibus_cmd_addr;
        end else if (icache_hs) begin
            s1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_va_q  <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_va_q  <= s1_va_d;
        end
    end

    // Exception FSM: a flush always wins over a fault detected in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_q       <= EXC_NONE;
            miss_q      <= 1'b0;
            pfault_q    <= 1'b0;
            exp_va_q    <= '0;
            flush_ack_q <= 1'b0;
        end else begin
            flush_ack_q <= ibus_cmd_flush;
            if (ibus_cmd_flush) begin
                exc_q    <= EXC_NONE;
                miss_q   <= 1'b0;
                pfault_q <= 1'b0;
            end else if (exc_q == EXC_NONE && s1_vld_q && msr_psr_imme && !tlb_ok) begin
                exc_q    <= tlb_hit ? EXC_PAGE_FAULT : EXC_TLB_MISS;
                miss_q   <= ~tlb_hit;
                pfault_q <= tlb_hit;
                exp_va_q <= s1_va_q;
            end
        end
    end

    assign exp_tlb_miss   = miss_q;
    assign exp_page_fault = pfault_q;
    assign exp_va         = exp_va_q;
    assign ibus_flush_ack = flush_ack_q;
    assign msr_immid      = {{(DW-3){1'b0}}, NSETS_LOG2_FIELD};

    assign ibus_dout_valid   = icache_dout_valid;
    assign icache_dout_ready = ibus_dout_ready;
    assign ibus_dout         = icache_dout;

endmodule

// File: tb/tb_ncpu32k_i_mmu_tlb.sv
// Bench for ncpu32k_i_mmu_tlb: reset checks, streaming/stall sequences, a
// table of single-fetch translations and a randomized run against a queue model.
module tb_ncpu32k_i_mmu_tlb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 32;
   localparam int NL2 = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ibusCmdValid = 1'b0, ibusCmdReady, ibusCmdFlush = 1'b0, ibusFlushAck;
   logic [AW-1:0] ibusCmdAddr = '0;
   logic icacheCmdValid, icacheCmdReady = 1'b0;
   logic [AW-1:0] icacheCmdAddr;
   logic icacheDoutValid = 1'b0, icacheDoutReady, ibusDoutValid, ibusDoutReady = 1'b0;
   logic [IW-1:0] icacheDout = '0, ibusDout;
   logic imme = 1'b0, rm = 1'b0;
   logic expTlbMiss, expPageFault;
   logic [AW-1:0] expVa;
   logic [DW-1:0] msrImmid, msrTlbl, msrTlbh;
   logic [NL2-1:0] tlblIdx = '0, tlbhIdx = '0;
   logic [DW-1:0] tlblNxt = '0, tlbhNxt = '0;
   logic tlblWe = 1'b0, tlbhWe = 1'b0;

   int testCount = 0;
   int failCount = 0;

   // Bench-side copy of the TLB contents, indexed like the hardware sets.
   logic [31:0] tlblM [4];
   logic [31:0] tlbhM [4];

   typedef struct {
      logic [31:0] va;
      logic        imme;
      logic        rm;
      int          kind;
      logic [31:0] pa;
   } vecT;
   vecT vecs[10];

   ncpu32k_i_mmu_tlb #(.TLB_NSETS_LOG2(NL2), .PAGE_SHIFT(13), .AW(AW), .DW(DW), .IW(IW)) dut (
      .clk(clk), .rst(rst),
      .ibus_cmd_valid(ibusCmdValid), .ibus_cmd_ready(ibusCmdReady), .ibus_cmd_addr(ibusCmdAddr),
      .ibus_cmd_flush(ibusCmdFlush), .ibus_flush_ack(ibusFlushAck),
      .icache_cmd_valid(icacheCmdValid), .icache_cmd_ready(icacheCmdReady), .icache_cmd_addr(icacheCmdAddr),
      .icache_dout_valid(icacheDoutValid), .icache_dout_ready(icacheDoutReady), .icache_dout(icacheDout),
      .ibus_dout_valid(ibusDoutValid), .ibus_dout_ready(ibusDoutReady), .ibus_dout(ibusDout),
      .msr_psr_imme(imme), .msr_psr_rm(rm),
      .exp_tlb_miss(expTlbMiss), .exp_page_fault(expPageFault), .exp_va(expVa),
      .msr_immid(msrImmid),
      .msr_imm_tlbl(msrTlbl), .msr_imm_tlbl_idx(tlblIdx), .msr_imm_tlbl_nxt(tlblNxt), .msr_imm_tlbl_we(tlblWe),
      .msr_imm_tlbh(msrTlbh), .msr_imm_tlbh_idx(tlbhIdx), .msr_imm_tlbh_nxt(tlbhNxt), .msr_imm_tlbh_we(tlbhWe)
   );

   always #5 clk = ~clk;

   // Guard against a hung simulation.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic flush, input logic icReady);
      ibusCmdValid = valid;
      ibusCmdAddr = addr;
      ibusCmdFlush = flush;
      icacheCmdReady = icReady;
   endtask

   // One-cycle MSR write; the model copy is updated alongside.
   task automatic writeTlb(input logic high, input int idx, input logic [31:0] data);
      if (high) begin
         tlbhIdx = NL2'(idx); tlbhNxt = data; tlbhWe = 1'b1; tlbhM[idx] = data;
      end else begin
         tlblIdx = NL2'(idx); tlblNxt = data; tlblWe = 1'b1; tlblM[idx] = data;
      end
      tick();
      tlblWe = 1'b0;
      tlbhWe = 1'b0;
   endtask

   // Reference translation straight from the entry format: set = VA[14:13].
   function automatic void lookupModel(input logic [31:0] va, input logic isSup,
                                       output logic hit, output logic allow, output logic [31:0] pa);
      int idx;
      logic [31:0] h;
      idx = int'((va >> 13) % 4);
      h = tlbhM[idx];
      hit = tlblM[idx][0] && ((tlblM[idx] >> 13) == (va >> 13));
      allow = hit && h[0] && (isSup ? h[2] : h[1]);
      pa = ((h >> 13) << 13) | (va & 32'h1FFF);
   endfunction

   initial begin
      logic [31:0] s1Q[$];
      int excKind;
      logic [31:0] excVa;
      logic ackM;
      logic hit, allow, expValid, expReady;
      logic [31:0] pa, va;

      for (int i = 0; i < 4; i++) begin
         tlblM[i] = '0;
         tlbhM[i] = '0;
      end

      vecs[0] = '{32'h0000_2004, 1'b0, 1'b0, 0, 32'h0000_2004};
      vecs[1] = '{32'h0000_2010, 1'b1, 1'b0, 0, 32'h0008_0010};
      vecs[2] = '{32'h0000_2010, 1'b1, 1'b1, 2, 32'h0};
      vecs[3] = '{32'h0000_4000, 1'b1, 1'b0, 1, 32'h0};
      vecs[4] = '{32'h0000_E008, 1'b1, 1'b0, 2, 32'h0};
      vecs[5] = '{32'h0000_E008, 1'b1, 1'b1, 0, 32'h000A_A008};
      vecs[6] = '{32'h0000_0100, 1'b1, 1'b0, 1, 32'h0};
      vecs[7] = '{32'h0000_A010, 1'b1, 1'b0, 1, 32'h0};
      vecs[8] = '{32'h0000_0100, 1'b0, 1'b1, 0, 32'h0000_0100};
      vecs[9] = '{32'h0000_3FFC, 1'b1, 1'b0, 0, 32'h0008_1FFC};

      // Reset state
      #12;
      settle();
      checkOutput("rst_icache_valid", 32'(icacheCmdValid), 32'd0);
      checkOutput("rst_miss", 32'(expTlbMiss), 32'd0);
      checkOutput("rst_pfault", 32'(expPageFault), 32'd0);
      checkOutput("rst_exp_va", expVa, 32'd0);
      checkOutput("rst_flush_ack", 32'(ibusFlushAck), 32'd0);
      checkOutput("rst_tlbl0", msrTlbl, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      settle();
      checkOutput("immid", msrImmid, 32'd2);
      checkOutput("idle_ready", 32'(ibusCmdReady), 32'd1);

      // Bypass streaming at one fetch per clock
      for (int k = 0; k < 4; k++) begin
         tick();
         applyStimulus(1'b1, 32'h0000_2004 + 32'(4 * k), 1'b0, 1'b1);
         settle();
         checkOutput("stream_ready", 32'(ibusCmdReady), 32'd1);
         checkOutput("stream_valid", 32'(icacheCmdValid), (k == 0) ? 32'd0 : 32'd1);
         if (k > 0) checkOutput("stream_addr", icacheCmdAddr, 32'h0000_2004 + 32'(4 * (k - 1)));
      end

      // icache back-pressure for three cycles
      for (int k = 0; k < 3; k++) begin
         tick();
         applyStimulus(1'b1, 32'h0000_2020, 1'b0, 1'b0);
         settle();
         checkOutput("stall_valid", 32'(icacheCmdValid), 32'd1);
         checkOutput("stall_addr", icacheCmdAddr, 32'h0000_2010);
         checkOutput("stall_ready", 32'(ibusCmdReady), 32'd0);
      end
      tick();
      applyStimulus(1'b1, 32'h0000_2020, 1'b0, 1'b1);
      settle();
      checkOutput("unstall_addr", icacheCmdAddr, 32'h0000_2010);
      checkOutput("unstall_ready", 32'(ibusCmdReady), 32'd1);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      settle();
      checkOutput("next_addr", icacheCmdAddr, 32'h0000_2020);
      checkOutput("next_valid", 32'(icacheCmdValid), 32'd1);
      tick();
      settle();
      checkOutput("drained_valid", 32'(icacheCmdValid), 32'd0);

      // TLB contents for the directed cases
      writeTlb(1'b0, 1, 32'h0000_2001);
      writeTlb(1'b1, 1, 32'h0008_0003);
      writeTlb(1'b0, 3, 32'h0000_E001);
      writeTlb(1'b1, 3, 32'h000A_A005);
      tlblIdx = 2'd1;
      tlbhIdx = 2'd3;
      settle();
      checkOutput("read_tlbl1", msrTlbl, 32'h0000_2001);
      checkOutput("read_tlbh3", msrTlbh, 32'h000A_A005);

      // Entry rewrite in the same cycle as its lookup
      tick();
      imme = 1'b1; rm = 1'b0;
      applyStimulus(1'b1, 32'h0000_2010, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tlbhIdx = 2'd1; tlbhNxt = 32'h0008_2003; tlbhWe = 1'b1; tlbhM[1] = 32'h0008_2003;
      settle();
      checkOutput("race_old_addr", icacheCmdAddr, 32'h0008_0010);
      checkOutput("race_valid", 32'(icacheCmdValid), 32'd1);
      tick();
      tlbhWe = 1'b0;
      icacheCmdReady = 1'b1;
      settle();
      checkOutput("race_new_addr", icacheCmdAddr, 32'h0008_2010);
      tick();
      settle();
      checkOutput("race_drained", 32'(icacheCmdValid), 32'd0);
      writeTlb(1'b1, 1, 32'h0008_0003);

      // Directed translation table
      foreach (vecs[v]) begin
         applyStimulus(1'b1, vecs[v].va, 1'b1, 1'b1);
         imme = vecs[v].imme;
         rm = vecs[v].rm;
         tick();
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
         settle();
         checkOutput($sformatf("vec%0d_ack", v), 32'(ibusFlushAck), 32'd1);
         checkOutput($sformatf("vec%0d_valid", v), 32'(icacheCmdValid), (vecs[v].kind == 0) ? 32'd1 : 32'd0);
         if (vecs[v].kind == 0) checkOutput($sformatf("vec%0d_pa", v), icacheCmdAddr, vecs[v].pa);
         tick();
         settle();
         checkOutput($sformatf("vec%0d_ack_once", v), 32'(ibusFlushAck), 32'd0);
         checkOutput($sformatf("vec%0d_miss", v), 32'(expTlbMiss), (vecs[v].kind == 1) ? 32'd1 : 32'd0);
         checkOutput($sformatf("vec%0d_pfault", v), 32'(expPageFault), (vecs[v].kind == 2) ? 32'd1 : 32'd0);
         checkOutput($sformatf("vec%0d_ready", v), 32'(ibusCmdReady), (vecs[v].kind == 0) ? 32'd1 : 32'd0);
         if (vecs[v].kind != 0) checkOutput($sformatf("vec%0d_exp_va", v), expVa, vecs[v].va);
         tick();
      end

      // Randomized traffic against the queue model
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      s1Q.delete();
      excKind = 0;
      excVa = '0;
      ackM = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         applyStimulus(($urandom % 4) != 0, ($urandom_range(0, 7) << 13) | ($urandom & 32'h1FFC),
                       ($urandom % 8) == 0, ($urandom % 3) != 0);
         imme = ($urandom % 4) != 0;
         rm = $urandom % 2;
         icacheDoutValid = $urandom % 2;
         ibusDoutReady = $urandom % 2;
         icacheDout = $urandom;
         tlblIdx = NL2'($urandom);
         tlbhIdx = NL2'($urandom);
         tlblNxt = ($urandom_range(0, 7) << 13) | ($urandom & 32'h1FFF);
         tlbhNxt = ($urandom_range(0, 255) << 13) | ($urandom & 32'h1FFF);
         tlblWe = ($urandom % 8) == 0;
         tlbhWe = ($urandom % 8) == 0;
         settle();

         va = (s1Q.size() > 0) ? s1Q[0] : 32'h0;
         lookupModel(va, rm, hit, allow, pa);
         expValid = (s1Q.size() > 0) && !ibusCmdFlush && excKind == 0 && (!imme || allow);
         expReady = ibusCmdFlush || (excKind == 0 && (s1Q.size() == 0 || (expValid && icacheCmdReady)));
         checkOutput("rnd_valid", 32'(icacheCmdValid), 32'(expValid));
         checkOutput("rnd_ready", 32'(ibusCmdReady), 32'(expReady));
         if (expValid) checkOutput("rnd_addr", icacheCmdAddr, imme ? pa : va);
         checkOutput("rnd_miss", 32'(expTlbMiss), 32'(excKind == 1));
         checkOutput("rnd_pfault", 32'(expPageFault), 32'(excKind == 2));
         if (excKind != 0) checkOutput("rnd_exp_va", expVa, excVa);
         checkOutput("rnd_ack", 32'(ibusFlushAck), 32'(ackM));
         checkOutput("rnd_tlbl_rd", msrTlbl, tlblM[tlblIdx]);
         checkOutput("rnd_tlbh_rd", msrTlbh, tlbhM[tlbhIdx]);
         checkOutput("rnd_dout", ibusDout, icacheDout);
         checkOutput("rnd_dout_hs", {30'd0, ibusDoutValid, icacheDoutReady}, {30'd0, icacheDoutValid, ibusDoutReady});

         ackM = ibusCmdFlush;
         if (ibusCmdFlush) begin
            excKind = 0;
            s1Q.delete();
            if (ibusCmdValid) s1Q.push_back(ibusCmdAddr);
         end else begin
            if (s1Q.size() > 0 && excKind == 0 && imme && !allow) begin
               excKind = hit ? 2 : 1;
               excVa = va;
            end
            if (expValid && icacheCmdReady) void'(s1Q.pop_front());
            if (ibusCmdValid && expReady) s1Q.push_back(ibusCmdAddr);
         end
         if (tlblWe) tlblM[tlblIdx] = tlblNxt;
         if (tlbhWe) tlbhM[tlbhIdx] = tlbhNxt;
         tick();
      end
      tlblWe = 1'b0;
      tlbhWe = 1'b0;

      // Reset in the middle of a stalled transfer
      imme = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      settle();
      checkOutput("pre_rst_valid", 32'(icacheCmdValid), 32'd1);
      rst = 1'b1;
      settle();
      checkOutput("mid_rst_valid", 32'(icacheCmdValid), 32'd0);
      checkOutput("mid_rst_ack", 32'(ibusFlushAck), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      settle();
      checkOutput("post_rst_valid", 32'(icacheCmdValid), 32'd0);
      checkOutput("post_rst_ready", 32'(ibusCmdReady), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
